// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bus between the timing generator and pixel pipelines
// The generator (master) drives timing; the consumer (slave) drives the run enable.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
);
  logic               en;
  logic               pix_tick;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               h_sync;
  logic               v_sync;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  en,
    output pix_tick, x, y, h_sync, v_sync, display_on,
    output line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  pix_tick, x, y, h_sync, v_sync, display_on,
    input  line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with pixel divider and sync delay line
// Syncs and display_on trail x/y by PIPE_DELAY pixel ticks so downstream pixel pipelines line up.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int PIX_DIV    = 1,
  parameter int PIPE_DELAY = 1,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  if (PIX_DIV < 1 || PIPE_DELAY < 1 ||
      H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cfg
    $error("vga_timing_gen: invalid PIX_DIV/PIPE_DELAY or totals exceed CNT_W");
  end

  logic [DIV_W-1:0]           div;
  logic [CNT_W-1:0]           x;
  logic [CNT_W-1:0]           y;
  logic [PIPE_DELAY-1:0][2:0] dly;
  logic                       line_start;
  logic                       frame_start;
  logic [FRAME_W-1:0]         frame_count;

  logic pix_tick;
  logic x_wrap;
  logic y_wrap;
  logic hs_raw;
  logic vs_raw;
  logic act_raw;

  // Gating with rst_n keeps the strobe quiet while reset is held.
  assign pix_tick = rst_n && bus.en && (div == DIV_W'(PIX_DIV - 1));
  assign x_wrap   = (x == CNT_W'(H_TOTAL - 1));
  assign y_wrap   = (y == CNT_W'(V_TOTAL - 1));

  assign hs_raw  = (x >= CNT_W'(H_DISPLAY + H_FRONT)) &&
                   (x <  CNT_W'(H_DISPLAY + H_FRONT + H_SYNC));
  assign vs_raw  = (y >= CNT_W'(V_DISPLAY + V_FRONT)) &&
                   (y <  CNT_W'(V_DISPLAY + V_FRONT + V_SYNC));
  assign act_raw = (x < CNT_W'(H_DISPLAY)) && (y < CNT_W'(V_DISPLAY));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div         <= '0;
      x           <= '0;
      y           <= '0;
      dly         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (bus.en) begin
        div <= (div == DIV_W'(PIX_DIV - 1)) ? '0 : div + 1'b1;
      end
      if (pix_tick) begin
        x <= x_wrap ? '0 : x + 1'b1;
        if (x_wrap) begin
          y <= y_wrap ? '0 : y + 1'b1;
        end
        // Stage 0 takes the decode of the pixel being left, before x/y advance.
        dly[0] <= {hs_raw, vs_raw, act_raw};
        for (int i = 1; i < PIPE_DELAY; i++) begin
          dly[i] <= dly[i-1];
        end
        line_start  <= x_wrap;
        frame_start <= x_wrap && y_wrap;
        if (x_wrap && y_wrap) begin
          frame_count <= frame_count + 1'b1;
        end
      end
    end
  end

  assign bus.pix_tick    = pix_tick;
  assign bus.x           = x;
  assign bus.y           = y;
  assign bus.h_sync      = dly[PIPE_DELAY-1][2] ? H_SYNC_POL : ~H_SYNC_POL;
  assign bus.v_sync      = dly[PIPE_DELAY-1][1] ? V_SYNC_POL : ~V_SYNC_POL;
  assign bus.display_on  = dly[PIPE_DELAY-1][0];
  assign bus.line_start  = line_start;
  assign bus.frame_start = frame_start;
  assign bus.frame_count = frame_count;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen with two configurations against a pixel-count model
// Reference derives every output from the number of enabled clocks since reset.
module tb_vga_timing_gen;
  logic clk;
  logic rstn_a;
  logic rstn_b;
  int   total;
  int   bad;
  int   cyc;

  localparam int HD [2] = '{8, 16};
  localparam int HF [2] = '{2, 4};
  localparam int HS [2] = '{2, 6};
  localparam int HB [2] = '{2, 6};
  localparam int VD [2] = '{4, 10};
  localparam int VF [2] = '{1, 2};
  localparam int VS [2] = '{1, 2};
  localparam int VB [2] = '{1, 3};
  localparam int DV [2] = '{3, 1};
  localparam int PD [2] = '{2, 1};
  localparam int POL[2] = '{0, 1};
  localparam int FW [2] = '{8, 2};

  vga_timing_gen_if #(.CNT_W(4), .FRAME_W(8)) bus_a ();
  vga_timing_gen_if #(.CNT_W(6), .FRAME_W(2)) bus_b ();

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .PIX_DIV(3), .PIPE_DELAY(2), .CNT_W(4), .FRAME_W(8)
  ) dut_a (.clk(clk), .rst_n(rstn_a), .bus(bus_a));

  vga_timing_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
    .PIX_DIV(1), .PIPE_DELAY(1), .CNT_W(6), .FRAME_W(2)
  ) dut_b (.clk(clk), .rst_n(rstn_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: enabled clocks since reset, and whether the last edge was a pixel tick.
  int e  [2];
  bit tl [2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (!(k == 1 ? rstn_b : rstn_a)) begin
        e[k]  <= 0;
        tl[k] <= 1'b0;
      end else if (k == 1 ? bus_b.en : bus_a.en) begin
        tl[k] <= (e[k] % DV[k] == DV[k] - 1);
        e[k]  <= e[k] + 1;
      end else begin
        tl[k] <= 1'b0;
      end
    end
  end

  function automatic int ht(int k);
    return HD[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int vt(int k);
    return VD[k] + VF[k] + VS[k] + VB[k];
  endfunction

  function automatic int exp_v(int k, int sel);
    int n, m, xx, yy;
    bit r, en, hs, vs, act;
    n  = e[k] / DV[k];
    m  = n - PD[k];
    r  = (k == 1) ? rstn_b : rstn_a;
    en = (k == 1) ? bus_b.en : bus_a.en;
    xx = (m >= 0) ? m % ht(k) : 0;
    yy = (m >= 0) ? (m / ht(k)) % vt(k) : 0;
    hs  = (m >= 0) && xx >= HD[k] + HF[k] && xx < HD[k] + HF[k] + HS[k];
    vs  = (m >= 0) && yy >= VD[k] + VF[k] && yy < VD[k] + VF[k] + VS[k];
    act = (m >= 0) && xx < HD[k] && yy < VD[k];
    case (sel)
      0: return n % ht(k);
      1: return (n / ht(k)) % vt(k);
      2: return int'(r && en && (e[k] % DV[k] == DV[k] - 1));
      3: return hs ? POL[k] : 1 - POL[k];
      4: return vs ? POL[k] : 1 - POL[k];
      5: return int'(act);
      6: return int'(tl[k] && n > 0 && n % ht(k) == 0);
      7: return int'(tl[k] && n > 0 && n % (ht(k) * vt(k)) == 0);
      8: return (n / (ht(k) * vt(k))) % (1 << FW[k]);
      default: return 0;
    endcase
  endfunction

  function automatic int got_v(int k, int sel);
    case (sel)
      0: return (k == 1) ? int'(bus_b.x) : int'(bus_a.x);
      1: return (k == 1) ? int'(bus_b.y) : int'(bus_a.y);
      2: return (k == 1) ? int'(bus_b.pix_tick) : int'(bus_a.pix_tick);
      3: return (k == 1) ? int'(bus_b.h_sync) : int'(bus_a.h_sync);
      4: return (k == 1) ? int'(bus_b.v_sync) : int'(bus_a.v_sync);
      5: return (k == 1) ? int'(bus_b.display_on) : int'(bus_a.display_on);
      6: return (k == 1) ? int'(bus_b.line_start) : int'(bus_a.line_start);
      7: return (k == 1) ? int'(bus_b.frame_start) : int'(bus_a.frame_start);
      8: return (k == 1) ? int'(bus_b.frame_count) : int'(bus_a.frame_count);
      default: return 0;
    endcase
  endfunction

  string nm [9] = '{"x", "y", "pix_tick", "h_sync", "v_sync", "display_on",
                    "line_start", "frame_start", "frame_count"};

  task automatic test_reset();
    int rst_exp [9];
    rstn_a = 1'b0; rstn_b = 1'b0;
    bus_a.en = 1'b1; bus_b.en = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rst_exp = '{0, 0, 0, 1 - POL[k], 1 - POL[k], 0, 0, 0, 0};
      for (int s = 0; s < 9; s++) begin
        total++;
        if (got_v(k, s) !== rst_exp[s]) begin
          bad++;
          $display("FAIL reset_%s dut%0d got=%0d exp=%0d", nm[s], k, got_v(k, s), rst_exp[s]);
        end
      end
    end
    rstn_a = 1'b1; rstn_b = 1'b1;
  endtask

  task automatic test_counters();
    repeat (1100) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < 3; s++) begin
          total++;
          if (got_v(k, s) !== exp_v(k, s)) begin
            bad++;
            $display("FAIL cnt_%s dut%0d cyc=%0d got=%0d exp=%0d", nm[s], k, cyc, got_v(k, s), exp_v(k, s));
          end
        end
    end
  endtask

  task automatic test_sync_decode();
    repeat (1100) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int s = 3; s < 6; s++) begin
          total++;
          if (got_v(k, s) !== exp_v(k, s)) begin
            bad++;
            $display("FAIL dec_%s dut%0d cyc=%0d got=%0d exp=%0d", nm[s], k, cyc, got_v(k, s), exp_v(k, s));
          end
        end
    end
  endtask

  task automatic test_strobes();
    int last [2] = '{-1, -1};
    repeat (1200) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        for (int s = 6; s < 9; s++) begin
          total++;
          if (got_v(k, s) !== exp_v(k, s)) begin
            bad++;
            $display("FAIL stb_%s dut%0d cyc=%0d got=%0d exp=%0d", nm[s], k, cyc, got_v(k, s), exp_v(k, s));
          end
        end
        if (got_v(k, 6) == 1) begin
          if (last[k] >= 0) begin
            total++;
            if (cyc - last[k] != ht(k) * DV[k]) begin
              bad++;
              $display("FAIL line_period dut%0d got=%0d exp=%0d", k, cyc - last[k], ht(k) * DV[k]);
            end
          end
          last[k] = cyc;
        end
      end
    end
  endtask

  task automatic test_en_random();
    repeat (700) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int s = 0; s < 9; s++) begin
          total++;
          if (got_v(k, s) !== exp_v(k, s)) begin
            bad++;
            $display("FAIL rnd_%s dut%0d cyc=%0d got=%0d exp=%0d", nm[s], k, cyc, got_v(k, s), exp_v(k, s));
          end
        end
      bus_a.en = ($urandom_range(3, 0) != 0);
      bus_b.en = ($urandom_range(3, 0) != 0);
    end
    bus_a.en = 1'b1; bus_b.en = 1'b1;
  endtask

  task automatic test_en_gap();
    int k, guard;
    bit seen_move;
    guard = 0;
    do begin @(negedge clk); guard++; end while (bus_a.x == 4'd5 && guard < 200);
    do begin @(negedge clk); guard++; end while (bus_a.x != 4'd5 && guard < 200);
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL gap_find_x5 got=timeout exp=x==5");
      return;
    end
    bus_a.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (bus_a.x !== 4'd5 || bus_a.pix_tick !== 1'b0 || bus_a.line_start !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold x=%0d tick=%0d ls=%0d exp x=5 tick=0 ls=0",
                 bus_a.x, bus_a.pix_tick, bus_a.line_start);
      end
    end
    bus_a.en = 1'b1;
    k = 7;
    seen_move = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (!seen_move && bus_a.x != 4'd5) begin
        seen_move = 1'b1;
        total++;
        if (bus_a.x !== 4'd6) begin
          bad++;
          $display("FAIL gap_next_x got=%0d exp=6", bus_a.x);
        end
      end
    end while (bus_a.line_start !== 1'b1 && k < 100);
    total++;
    if (k != 34) begin
      bad++;
      $display("FAIL gap_line_start_delay got=%0d exp=34", k);
    end
  endtask

  task automatic test_reset_mid();
    int guard, k;
    int ty [2] = '{3, 5};
    for (int d = 0; d < 2; d++) begin
      guard = 0;
      while (got_v(d, 1) != ty[d] && guard < 2000) begin @(negedge clk); guard++; end
      repeat (2) @(negedge clk);
      if (d == 1) rstn_b = 1'b0; else rstn_a = 1'b0;
      @(negedge clk);
      if (d == 1) rstn_b = 1'b1; else rstn_a = 1'b1;
      for (int s = 0; s < 9; s++) begin
        if (s == 2) continue;
        total++;
        if (got_v(d, s) !== ((s == 3 || s == 4) ? 1 - POL[d] : 0)) begin
          bad++;
          $display("FAIL midrst_%s dut%0d got=%0d exp=%0d", nm[s], d, got_v(d, s),
                   (s == 3 || s == 4) ? 1 - POL[d] : 0);
        end
      end
      k = 0;
      do begin @(negedge clk); k++; end while (got_v(d, 7) != 1 && k < 2000);
      total++;
      if (k != ht(d) * vt(d) * DV[d]) begin
        bad++;
        $display("FAIL midrst_first_frame dut%0d got=%0d exp=%0d", d, k, ht(d) * vt(d) * DV[d]);
      end
    end
  endtask

  task automatic test_polarity_frames();
    int fc_q[$];
    int want [4] = '{1, 2, 3, 0};
    int k;
    rstn_b = 1'b0;
    @(negedge clk);
    rstn_b = 1'b1;
    total++;
    if (bus_b.h_sync !== 1'b0 || bus_b.v_sync !== 1'b0) begin
      bad++;
      $display("FAIL pol_idle hs=%0d vs=%0d exp hs=0 vs=0", bus_b.h_sync, bus_b.v_sync);
    end
    k = 0;
    while (fc_q.size() < 4 && k < 4 * 544 + 100) begin
      @(negedge clk);
      k++;
      if (bus_b.frame_start === 1'b1) fc_q.push_back(int'(bus_b.frame_count));
    end
    total++;
    if (fc_q.size() != 4) begin
      bad++;
      $display("FAIL pol_frames got=%0d exp=4", fc_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (fc_q[i] != want[i]) begin
          bad++;
          $display("FAIL pol_frame_count[%0d] got=%0d exp=%0d", i, fc_q[i], want[i]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    test_reset();
    test_counters();
    test_sync_decode();
    test_strobes();
    test_en_random();
    test_en_gap();
    test_reset_mid();
    test_polarity_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
